approxexp_v2_block: RTL and testbench

APPROXEXP_V2_BLOCK -- requirements
Module: approxexp_v2

---
 rtl/approxexp_v2_block_if.sv | 21 ++
 rtl/approxexp_v2_block.sv | 198 +++++++++++++++++++
 tb/tb_approxexp_v2_block.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/approxexp_v2_block_if.sv
// Streaming handshake bundle for approxexp_v2_block: sample in (ccs, x) and result out.
`timescale 1ns/1ps
interface approxexp_v2_block_if;
   logic        din_val;
   logic        din_rdy;
   logic [63:0] ccs_i;
   logic [63:0] x_i;
   logic        dout_val;
   logic        dout_rdy;
   logic [63:0] exp_o;

   modport master (
      output din_val, ccs_i, x_i, dout_rdy,
      input  din_rdy, dout_val, exp_o
   );

   modport slave (
      input  din_val, ccs_i, x_i, dout_rdy,
      output din_rdy, dout_val, exp_o
   );
endinterface

// File: rtl/approxexp_v2_block.sv
// Pipelined fixed-point ccs*exp(-x)*2^63: double->Q1.63 conversion, 12-step Horner, ccs scale.
// Define APPROXEXP_IN_CLAMP_EN to clamp negative/NaN inputs to 0 and inputs >= 2.0 to all-ones.
`timescale 1ns/1ps
module approxexp_v2_block #(
   parameter int MULT_OPT             = 0,
   parameter int FLOOR_OUTPUT_LATENCY = 1,
   parameter int MULT_OUTPUT_LATENCY  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   approxexp_v2_block_if.slave  bus
);

   localparam logic [63:0] COEF [0:12] = '{
      64'h00000004741183A3, 64'h00000036548CFC06, 64'h0000024FDCBF140A,
      64'h0000171D939DE045, 64'h0000D00CF58F6F84, 64'h000680681CF796E3,
      64'h002D82D8305B0FEA, 64'h011111110E066FD0, 64'h0555555555070F00,
      64'h155555555581FF00, 64'h400000000002B400, 64'h7FFFFFFFFFFF4800,
      64'h8000000000000000
   };

   function automatic logic [63:0] fix_f(input logic [63:0] d);
      logic [10:0]        e;
      logic [63:0]        m;
      logic signed [12:0] sh;
      logic [12:0]        rs;
`ifndef APPROXEXP_IN_CLAMP_EN
      logic               sign_unused;
`endif
      e  = d[62:52];
      m  = {11'd0, 1'b1, d[51:0]};
      sh = $signed({2'b00, e}) - 13'sd1012;
      rs = 13'(-sh);
      fix_f = '0;
      if (e == 11'd0)
         fix_f = '0;
      else if (sh >= 13'sd0)
         fix_f = (sh > 13'sd63) ? '0 : m << sh[5:0];
      else
         fix_f = (rs > 13'd52) ? '0 : m >> rs[5:0];
`ifdef APPROXEXP_IN_CLAMP_EN
      if (d[63] || (e == 11'h7FF && d[51:0] != 52'd0))
         fix_f = '0;
      else if (e >= 11'd1024)
         fix_f = '1;
`else
      sign_unused = d[63];
`endif
   endfunction

   function automatic logic [63:0] mul_hi(input logic [63:0] a, input logic [63:0] b);
      mul_hi = 64'(({64'd0, a} * {64'd0, b}) >> 63);
   endfunction

   // Recombine four 32x32 partial products into bits [126:63] of the 128-bit product.
   function automatic logic [63:0] pp_sum(input logic [63:0] hh, input logic [63:0] hl,
                                          input logic [63:0] lh, input logic [63:0] ll);
      pp_sum = 64'(({hh, 64'd0} + {32'd0, hl, 32'd0} + {32'd0, lh, 32'd0} + {64'd0, ll}) >> 63);
   endfunction

   logic        adv;
   logic [63:0] xf_p0, cf_p0;
   logic        vld_p0;
   logic [63:0] mp [0:12];
   logic [63:0] mz [0:12];
   logic [63:0] ms [0:12];
   logic        mv [0:12];
   logic        unused_tail;

   // Whole pipeline moves as one; a stalled output freezes every stage.
   assign adv           = bus.dout_rdy | ~bus.dout_val;
   assign bus.din_rdy   = adv;
   assign bus.exp_o     = mp[12];
   assign bus.dout_val  = mv[12];
   assign unused_tail   = ^{mz[12], ms[12]};

   // ---- stage p0: double -> fixed conversion ----
   if (FLOOR_OUTPUT_LATENCY == 0) begin : g_cvt
      assign xf_p0  = fix_f(bus.x_i);
      assign cf_p0  = fix_f(bus.ccs_i);
      assign vld_p0 = bus.din_val;
   end else begin : g_cvt
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            xf_p0  <= '0;
            cf_p0  <= '0;
            vld_p0 <= 1'b0;
         end else if (adv) begin
            xf_p0  <= fix_f(bus.x_i);
            cf_p0  <= fix_f(bus.ccs_i);
            vld_p0 <= bus.din_val;
         end
      end
   end

   for (genvar j = 0; j <= 12; j++) begin : g_st
      logic [63:0] y_p1, z_p1, s_p1, a_op;
      logic        vld_p1;

      // ---- stage p1: subtract closing Horner step j ----
      if (j == 0) begin : g_src
         assign y_p1   = COEF[0];
         assign z_p1   = xf_p0;
         assign s_p1   = cf_p0;
         assign vld_p1 = vld_p0;
      end else begin : g_src
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               y_p1   <= '0;
               z_p1   <= '0;
               s_p1   <= '0;
               vld_p1 <= 1'b0;
            end else if (adv) begin
               y_p1   <= COEF[j] - mp[j-1];
               z_p1   <= mz[j-1];
               s_p1   <= ms[j-1];
               vld_p1 <= mv[j-1];
            end
         end
      end

      // The 13th multiply applies the ccs scale instead of z.
      assign a_op = (j == 12) ? s_p1 : z_p1;

      // ---- stages p2/p3: 64x64 multiply, keep bits [126:63] ----
      if (MULT_OUTPUT_LATENCY == 1) begin : g_mul
         logic [63:0] prod_p2, z_p2, s_p2;
         logic        vld_p2;
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               prod_p2 <= '0;
               z_p2    <= '0;
               s_p2    <= '0;
               vld_p2  <= 1'b0;
            end else if (adv) begin
               prod_p2 <= mul_hi(a_op, y_p1);
               z_p2    <= z_p1;
               s_p2    <= s_p1;
               vld_p2  <= vld_p1;
            end
         end
         assign mp[j] = prod_p2;
         assign mz[j] = z_p2;
         assign ms[j] = s_p2;
         assign mv[j] = vld_p2;
      end else if (MULT_OPT == 0) begin : g_mul
         logic [63:0] hh_p2, hl_p2, lh_p2, ll_p2, z_p2, s_p2, prod_p3, z_p3, s_p3;
         logic        vld_p2, vld_p3;
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               hh_p2 <= '0; hl_p2 <= '0; lh_p2 <= '0; ll_p2 <= '0;
               z_p2 <= '0; s_p2 <= '0; vld_p2 <= 1'b0;
               prod_p3 <= '0; z_p3 <= '0; s_p3 <= '0; vld_p3 <= 1'b0;
            end else if (adv) begin
               hh_p2   <= {32'd0, a_op[63:32]} * {32'd0, y_p1[63:32]};
               hl_p2   <= {32'd0, a_op[63:32]} * {32'd0, y_p1[31:0]};
               lh_p2   <= {32'd0, a_op[31:0]}  * {32'd0, y_p1[63:32]};
               ll_p2   <= {32'd0, a_op[31:0]}  * {32'd0, y_p1[31:0]};
               z_p2    <= z_p1;
               s_p2    <= s_p1;
               vld_p2  <= vld_p1;
               prod_p3 <= pp_sum(hh_p2, hl_p2, lh_p2, ll_p2);
               z_p3    <= z_p2;
               s_p3    <= s_p2;
               vld_p3  <= vld_p2;
            end
         end
         assign mp[j] = prod_p3;
         assign mz[j] = z_p3;
         assign ms[j] = s_p3;
         assign mv[j] = vld_p3;
      end else begin : g_mul
         // Full product first, trailing register left for retiming.
         logic [63:0] prod_p2, z_p2, s_p2, prod_p3, z_p3, s_p3;
         logic        vld_p2, vld_p3;
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               prod_p2 <= '0; z_p2 <= '0; s_p2 <= '0; vld_p2 <= 1'b0;
               prod_p3 <= '0; z_p3 <= '0; s_p3 <= '0; vld_p3 <= 1'b0;
            end else if (adv) begin
               prod_p2 <= mul_hi(a_op, y_p1);
               z_p2    <= z_p1;
               s_p2    <= s_p1;
               vld_p2  <= vld_p1;
               prod_p3 <= prod_p2;
               z_p3    <= z_p2;
               s_p3    <= s_p2;
               vld_p3  <= vld_p2;
            end
         end
         assign mp[j] = prod_p3;
         assign mz[j] = z_p3;
         assign ms[j] = s_p3;
         assign mv[j] = vld_p3;
      end
   end

endmodule

// File: tb/tb_approxexp_v2_block.sv
// Scoreboard bench for approxexp_v2_block: directed vectors, random stream with stalls, mid-flight reset.
`timescale 1ns/1ps
module tb_approxexp_v2_block;
   localparam int LAT = 39;
   localparam logic [63:0] COEF [0:12] = '{
      64'h00000004741183A3, 64'h00000036548CFC06, 64'h0000024FDCBF140A,
      64'h0000171D939DE045, 64'h0000D00CF58F6F84, 64'h000680681CF796E3,
      64'h002D82D8305B0FEA, 64'h011111110E066FD0, 64'h0555555555070F00,
      64'h155555555581FF00, 64'h400000000002B400, 64'h7FFFFFFFFFFF4800,
      64'h8000000000000000
   };
   localparam logic [63:0] D_ONE  = 64'h3FF0000000000000;
   localparam logic [63:0] D_HALF = 64'h3FE0000000000000;
   localparam logic [63:0] D_QTR  = 64'h3FD0000000000000;
   localparam logic [63:0] D_1P5  = 64'h3FF8000000000000;
   localparam logic [63:0] D_TWO  = 64'h4000000000000000;
   localparam logic [63:0] D_NEG1 = 64'hBFF0000000000000;
   localparam logic [63:0] D_INF  = 64'h7FF0000000000000;
   localparam logic [63:0] D_NAN  = 64'h7FF8000000000000;
   localparam logic [63:0] D_NZ   = 64'h8000000000000000;
   localparam logic [63:0] D_X62  = 64'h3C10000000000000;
   localparam logic [63:0] D_SUB  = 64'h0000000000000001;

   typedef struct {
      logic [63:0] val;
      int          t;
      bit          lat;
   } sb_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   sb_t  sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   rnd_rdy = 1'b0;

   approxexp_v2_block_if bus();

   approxexp_v2_block #(
      .MULT_OPT(0), .FLOOR_OUTPUT_LATENCY(1), .MULT_OUTPUT_LATENCY(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (rnd_rdy) bus.dout_rdy = 1'($urandom_range(0, 1));
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   function automatic logic [63:0] m_fix(input logic [63:0] d);
      int           sh;
      logic [127:0] m;
      if (d[62:52] == 11'd0) return 64'd0;
`ifdef APPROXEXP_IN_CLAMP_EN
      if (d[63] || (d[62:52] == 11'h7FF && d[51:0] != 52'd0)) return 64'd0;
      if (d[62:52] >= 11'd1024) return '1;
`endif
      m  = {75'd0, 1'b1, d[51:0]};
      sh = int'(d[62:52]) - 1023 + 11;
      if (sh >= 64 || sh <= -64) return 64'd0;
      if (sh >= 0) m = m << sh;
      else m = m >> (-sh);
      return m[63:0];
   endfunction

   function automatic logic [63:0] m_exp(input logic [63:0] ccs, input logic [63:0] x);
      logic [63:0]  z, y;
      logic [127:0] p;
      z = m_fix(x);
      y = COEF[0];
      for (int i = 1; i <= 12; i++) begin
         p = {64'd0, z} * {64'd0, y};
         y = COEF[i] - p[126:63];
      end
      p = {64'd0, m_fix(ccs)} * {64'd0, y};
      return p[126:63];
   endfunction

   function automatic logic [63:0] rnd_dbl(input real scale);
      return $realtobits(scale * real'($urandom_range(0, 1000000)) / 1000000.0);
   endfunction

   task automatic send(input logic [63:0] ccs, input logic [63:0] x,
                       input logic [63:0] req, input bit lat);
      int  n;
      bit  ok;
      sb_t e;
      bus.ccs_i   = ccs;
      bus.x_i     = x;
      bus.din_val = 1'b1;
      n  = 0;
      ok = 1'b0;
      while (!ok && n <= 1000) begin
         @(negedge clk);
         if (bus.din_rdy) ok = 1'b1;
         n++;
      end
      if (ok) begin
         e.val = req;
         e.t   = cyc;
         e.lat = lat;
         sb.push_back(e);
      end else begin
         checks++;
         errors++;
         $display("FAIL din_rdy_timeout: got din_rdy=0 for %0d cycles, expected acceptance", n);
      end
      @(posedge clk);
      #1;
      bus.din_val = 1'b0;
   endtask

   task automatic idle(input int n);
      bus.din_val = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (sb.size() > 0 && n < 400) begin
         @(posedge clk);
         n++;
      end
      check64({"drain_", name}, 64'(sb.size()), 64'd0);
   endtask

   // Monitor: pops the scoreboard on every output transfer and checks stall behaviour.
   initial begin
      bit          prev_stall;
      logic [63:0] prev_exp;
      sb_t         e;
      prev_stall = 1'b0;
      prev_exp   = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_stall = 1'b0;
            continue;
         end
         check64("din_rdy", {63'd0, bus.din_rdy}, {63'd0, bus.dout_rdy | ~bus.dout_val});
         if (prev_stall) begin
            check64("stall_val", {63'd0, bus.dout_val}, 64'd1);
            check64("stall_exp", bus.exp_o, prev_exp);
         end
         if (bus.dout_val && bus.dout_rdy) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got exp_o=%h, expected no output", bus.exp_o);
            end else begin
               e = sb.pop_front();
               check64("exp_o", bus.exp_o, e.val);
               if (e.lat) check64("latency", 64'(cyc - e.t), 64'(LAT));
            end
         end
         prev_stall = bus.dout_val && !bus.dout_rdy;
         prev_exp   = bus.exp_o;
      end
   end

   initial begin
      logic [63:0] c, x;
      bus.din_val  = 1'b0;
      bus.ccs_i    = '0;
      bus.x_i      = '0;
      bus.dout_rdy = 1'b1;
      #1 rst = 1'b0;
      #2;
      check64("rst_dout_val", {63'd0, bus.dout_val}, 64'd0);
      check64("rst_exp_o", bus.exp_o, 64'd0);
      check64("rst_din_rdy", {63'd0, bus.din_rdy}, 64'd1);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;

      // Directed vectors, back-to-back, no back-pressure.
      send(D_ONE,  64'd0, 64'h8000000000000000, 1'b1);
      send(D_HALF, 64'd0, 64'h4000000000000000, 1'b1);
      send(64'd0,  64'd0, 64'h0000000000000000, 1'b1);
      send(D_QTR,  64'd0, 64'h2000000000000000, 1'b1);
      send(D_1P5,  64'd0, 64'hC000000000000000, 1'b1);
      send(D_ONE,  D_X62, 64'h7FFFFFFFFFFFFFFF, 1'b1);
      send(D_HALF, D_X62, 64'h3FFFFFFFFFFFFFFF, 1'b1);
      send(D_ONE,  D_SUB, 64'h8000000000000000, 1'b1);
      send(D_ONE,  D_NZ,  64'h8000000000000000, 1'b1);
      send(D_NAN,  64'd0, 64'h0000000000000000, 1'b1);
`ifdef APPROXEXP_IN_CLAMP_EN
      send(D_TWO,  64'd0, 64'hFFFFFFFFFFFFFFFF, 1'b1);
      send(D_NEG1, 64'd0, 64'h0000000000000000, 1'b1);
      send(D_ONE,  D_NEG1, 64'h8000000000000000, 1'b1);
      send(D_ONE,  D_INF, m_exp(D_ONE, D_INF), 1'b1);
`else
      send(D_TWO,  64'd0, 64'h0000000000000000, 1'b1);
      send(D_NEG1, 64'd0, 64'h8000000000000000, 1'b1);
      send(D_ONE,  D_NEG1, m_exp(D_ONE, D_NEG1), 1'b1);
      send(D_ONE,  D_INF, 64'h8000000000000000, 1'b1);
`endif
      for (int i = 0; i < 20; i++) begin
         c = rnd_dbl(1.0);
         x = rnd_dbl(0.6931);
         send(c, x, m_exp(c, x), 1'b1);
      end
      wait_drain("directed");

      // 100-sample stream with random back-pressure and input bubbles.
      rnd_rdy = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if ($urandom_range(0, 4) == 0) idle(1);
         c = rnd_dbl(1.0);
         x = rnd_dbl(0.6931);
         send(c, x, m_exp(c, x), 1'b0);
      end
      rnd_rdy = 1'b0;
      @(posedge clk);
      #2 bus.dout_rdy = 1'b1;
      wait_drain("stream");

      // Reset with 10 samples in flight: none of them may ever appear.
      for (int i = 0; i < 10; i++) send(D_ONE, 64'd0, 64'h8000000000000000, 1'b0);
      #2 rst = 1'b0;
      #1;
      check64("midrst_dout_val", {63'd0, bus.dout_val}, 64'd0);
      check64("midrst_exp_o", bus.exp_o, 64'd0);
      sb.delete();
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      repeat (60) @(posedge clk);
      #1;
      send(D_HALF, 64'd0, 64'h4000000000000000, 1'b1);
      wait_drain("post_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
